// File: rtl/inject_arbiter.sv
// Round-robin arbiter sharing one credit-based flit injection link between N_REQ sources.
// Optional per-source cumulative flit counters are built when INJECT_ARBITER_CNT_EN is defined.
module inject_arbiter #(
    parameter int N_REQ     = 2,
    parameter int FLIT_SIZE = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_REQ-1:0]           tx_i,
    input  logic [N_REQ*FLIT_SIZE-1:0] data_i,
    output logic [N_REQ-1:0]           credit_o,
    output logic                       tx_o,
    input  logic                       credit_i,
    output logic [FLIT_SIZE-1:0]       data_o,
    output logic [N_REQ-1:0]           grant_o,
    output logic                       busy_o,
    output logic [31:0]                burst_cnt_o,
    output logic [N_REQ*32-1:0]        flit_cnt_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   gnt_idx, gnt_idx_next;
    logic [IDX_W-1:0]   last_idx, last_idx_next;
    logic [31:0]        burst_cnt, burst_cnt_next;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic               pick_valid;
    logic               tx_sel;
    logic [FLIT_SIZE-1:0] data_sel;
    logic               xfer;

    // Rotating priority search starting just after the most recently served source.
    always_comb begin
        pick_idx   = '0;
        pick_valid = 1'b0;
        cand_idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand_idx = IDX_W'((int'(last_idx) + i) % N_REQ);
            if (!pick_valid && tx_i[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        data_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_idx == IDX_W'(k)) begin
                data_sel = data_i[k*FLIT_SIZE +: FLIT_SIZE];
            end
        end
    end

    assign tx_sel = tx_i[gnt_idx];
    assign xfer   = (state == GRANT) && tx_sel && credit_i;

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state     <= IDLE;
            gnt_idx   <= '0;
            last_idx  <= IDX_W'(N_REQ - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_next;
            gnt_idx   <= gnt_idx_next;
            last_idx  <= last_idx_next;
            burst_cnt <= burst_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        gnt_idx_next   = gnt_idx;
        last_idx_next  = last_idx;
        burst_cnt_next = burst_cnt;
        tx_o           = 1'b0;
        credit_o       = '0;
        data_o         = '0;
        grant_o        = '0;
        busy_o         = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt_idx_next   = pick_idx;
                    burst_cnt_next = '0;
                    state_next     = GRANT;
                end
            end
            GRANT: begin
                tx_o              = tx_sel;
                data_o            = data_sel;
                credit_o[gnt_idx] = credit_i;
                grant_o[gnt_idx]  = 1'b1;
                busy_o            = 1'b1;
                // Release takes priority; a dropped tx cannot transfer anyway.
                if (!tx_sel) begin
                    last_idx_next = gnt_idx;
                    state_next    = IDLE;
                end else if (xfer) begin
                    burst_cnt_next = burst_cnt + 32'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign burst_cnt_o = burst_cnt;

`ifdef INJECT_ARBITER_CNT_EN
    logic [31:0] flit_cnt [N_REQ];

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            for (int k = 0; k < N_REQ; k++) begin
                flit_cnt[k] <= '0;
            end
        end else if (xfer) begin
            flit_cnt[gnt_idx] <= flit_cnt[gnt_idx] + 32'd1;
        end
    end

    always_comb begin
        flit_cnt_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            flit_cnt_o[k*32 +: 32] = flit_cnt[k];
        end
    end
`else
    assign flit_cnt_o = '0;
`endif

endmodule

// File: tb/tb_inject_arbiter.sv
// Self-checking bench for inject_arbiter: directed scenarios plus a random phase,
// all compared against a burst-level reference model of the arbitration rules.
module tb_inject_arbiter;

    localparam int N_REQ     = 2;
    localparam int FLIT_SIZE = 32;

    logic                       clk_i = 1'b0;
    logic                       rst_ni = 1'b1;
    logic [N_REQ-1:0]           tx_i = '0;
    logic [N_REQ*FLIT_SIZE-1:0] data_i = '0;
    logic [N_REQ-1:0]           credit_o;
    logic                       tx_o;
    logic                       credit_i = 1'b0;
    logic [FLIT_SIZE-1:0]       data_o;
    logic [N_REQ-1:0]           grant_o;
    logic                       busy_o;
    logic [31:0]                burst_cnt_o;
    logic [N_REQ*32-1:0]        flit_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who owns the link (-1 when idle), who was served last, counts.
    int          m_owner;
    int          m_last;
    logic [31:0] m_burst;
    logic [31:0] m_flit [N_REQ];

    inject_arbiter #(.N_REQ(N_REQ), .FLIT_SIZE(FLIT_SIZE)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .tx_i(tx_i), .data_i(data_i),
        .credit_o(credit_o), .tx_o(tx_o), .credit_i(credit_i), .data_o(data_o),
        .grant_o(grant_o), .busy_o(busy_o), .burst_cnt_o(burst_cnt_o),
        .flit_cnt_o(flit_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_reset();
        m_owner = -1;
        m_last  = N_REQ - 1;
        m_burst = '0;
        for (int k = 0; k < N_REQ; k++) m_flit[k] = '0;
    endtask

    task automatic model_clock();
        if (m_owner < 0) begin
            for (int i = 1; i <= N_REQ; i++) begin
                int c;
                c = (m_last + i) % N_REQ;
                if (m_owner < 0 && tx_i[c]) begin
                    m_owner = c;
                    m_burst = '0;
                end
            end
        end else if (!tx_i[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end else if (credit_i) begin
            m_burst = m_burst + 32'd1;
            m_flit[m_owner] = m_flit[m_owner] + 32'd1;
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput();
        logic [N_REQ-1:0]     e_grant, e_credit;
        logic                 e_tx, e_busy;
        logic [FLIT_SIZE-1:0] e_data;
        logic [N_REQ*32-1:0]  e_cnt;
        e_grant = '0; e_credit = '0; e_tx = 1'b0; e_busy = 1'b0; e_data = '0; e_cnt = '0;
        if (m_owner >= 0) begin
            e_grant[m_owner]  = 1'b1;
            e_credit[m_owner] = credit_i;
            e_tx   = tx_i[m_owner];
            e_busy = 1'b1;
            e_data = data_i[m_owner*FLIT_SIZE +: FLIT_SIZE];
        end
`ifdef INJECT_ARBITER_CNT_EN
        for (int k = 0; k < N_REQ; k++) e_cnt[k*32 +: 32] = m_flit[k];
`endif
        check32("grant_o", 32'(grant_o), 32'(e_grant));
        check32("credit_o", 32'(credit_o), 32'(e_credit));
        check32("tx_o", 32'(tx_o), 32'(e_tx));
        check32("busy_o", 32'(busy_o), 32'(e_busy));
        check32("data_o", data_o, e_data);
        check32("burst_cnt_o", burst_cnt_o, m_burst);
        for (int k = 0; k < N_REQ; k++) begin
            check32("flit_cnt_o", flit_cnt_o[k*32 +: 32], e_cnt[k*32 +: 32]);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check, clock the model with the DUT.
    task automatic applyStimulus(input logic [N_REQ-1:0] tx, input logic cr,
                                 input logic [31:0] d0, input logic [31:0] d1);
        tx_i = tx;
        credit_i = cr;
        data_i = {d1, d0};
        #1 checkOutput();
        @(posedge clk_i);
        model_clock();
        @(negedge clk_i);
    endtask

    task automatic doReset();
        rst_ni = 1'b1;
        model_reset();
        tx_i = '0;
        credit_i = 1'b0;
        #1 checkOutput();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
    endtask

    initial begin
        logic [N_REQ-1:0] rtx;
        rtx = '0;
        model_reset();
        @(negedge clk_i);
        doReset();

        $display("[TB] single source burst of 10 flits");
        applyStimulus(2'b01, 1'b1, 32'h1, 32'h0);
        check32("grant_after_req", 32'(grant_o), 32'h1);
        for (int v = 1; v <= 10; v++) begin
            tx_i = 2'b01;
            data_i = {32'h0, 32'(v)};
            #1 check32("seq_data_o", data_o, 32'(v));
            applyStimulus(2'b01, 1'b1, 32'(v), 32'h0);
        end
        applyStimulus(2'b00, 1'b1, 32'h0, 32'h0);
        check32("burst_len_10", burst_cnt_o, 32'd10);
        check32("idle_after_burst", 32'(busy_o), 32'd0);

        $display("[TB] simultaneous requests and rotation");
        doReset();
        applyStimulus(2'b11, 1'b1, 32'hA0, 32'hB0);
        check32("first_win_src0", 32'(grant_o), 32'h1);
        for (int v = 1; v <= 3; v++) applyStimulus(2'b11, 1'b1, 32'hA0 + v, 32'hB0);
        applyStimulus(2'b10, 1'b1, 32'h0, 32'hB0);
        check32("bubble_idle", 32'(grant_o), 32'h0);
        applyStimulus(2'b10, 1'b1, 32'h0, 32'hB0);
        check32("then_src1", 32'(grant_o), 32'h2);
        for (int v = 1; v <= 3; v++) applyStimulus(2'b10, 1'b1, 32'h0, 32'hB0 + v);
        applyStimulus(2'b00, 1'b1, 32'h0, 32'h0);
        applyStimulus(2'b11, 1'b1, 32'hC1, 32'hD1);
        check32("rotation_src0", 32'(grant_o), 32'h1);
        applyStimulus(2'b01, 1'b1, 32'hC1, 32'h0);
        applyStimulus(2'b00, 1'b1, 32'h0, 32'h0);

        $display("[TB] backpressure");
        applyStimulus(2'b11, 1'b1, 32'h10, 32'h20);
        begin
            logic cr_seq [7];
            logic [31:0] d;
            cr_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
            d = 32'h11;
            for (int c = 0; c < 7; c++) begin
                logic [N_REQ-1:0] t;
                t = (m_burst == 32'd4) ? 2'b10 : 2'b11;
                applyStimulus(t, cr_seq[c], d, 32'h20);
                if (cr_seq[c] && t[0]) d = d + 32'd1;
            end
        end
        check32("bp_four_xfers", burst_cnt_o, 32'd4);

        $display("[TB] reset mid-burst");
        doReset();
        applyStimulus(2'b01, 1'b1, 32'h50, 32'h0);
        for (int v = 0; v < 5; v++) applyStimulus(2'b11, 1'b1, 32'h50 + v, 32'h60);
        #2 rst_ni = 1'b1;
        model_reset();
        #1 check32("rst_tx_o", 32'(tx_o), 32'd0);
        check32("rst_credit_o", 32'(credit_o), 32'd0);
        check32("rst_grant_o", 32'(grant_o), 32'd0);
        checkOutput();
        @(negedge clk_i);
        rst_ni = 1'b0;
        applyStimulus(2'b11, 1'b1, 32'h70, 32'h80);
        check32("post_rst_src0", 32'(grant_o), 32'h1);
        applyStimulus(2'b10, 1'b1, 32'h0, 32'h80);
        applyStimulus(2'b00, 1'b1, 32'h0, 32'h0);

        $display("[TB] interleaved bursts 4/6/2");
        doReset();
        begin
            int lens [3];
            int srcs [3];
            lens = '{4, 6, 2};
            srcs = '{0, 1, 0};
            for (int b = 0; b < 3; b++) begin
                logic [N_REQ-1:0] t;
                t = '0;
                t[srcs[b]] = 1'b1;
                applyStimulus(t, 1'b1, 32'h1, 32'h2);
                for (int v = 0; v < lens[b]; v++) applyStimulus(t, 1'b1, 32'h100 + v, 32'h200 + v);
                applyStimulus(2'b00, 1'b1, 32'h0, 32'h0);
            end
        end
`ifdef INJECT_ARBITER_CNT_EN
        check32("cnt_src0", flit_cnt_o[31:0], 32'd6);
        check32("cnt_src1", flit_cnt_o[63:32], 32'd6);
`else
        check32("cnt_off_src0", flit_cnt_o[31:0], 32'd0);
        check32("cnt_off_src1", flit_cnt_o[63:32], 32'd0);
`endif

        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if ($urandom_range(0, 3) == 0) rtx[k] = ~rtx[k];
            end
            applyStimulus(rtx, ($urandom_range(0, 3) != 0), $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inject_arbiter.md
# inject_arbiter

Round-robin arbiter that shares one credit-based flit injection link (tx/credit/data) between `N_REQ` stimulus sources, such as the management-application injector and application injectors. It sits between the sources and the injection port of the NoC under test. It grants the link to one source for a whole burst: from the source raising `tx` until it drops it. Granted traffic is forwarded combinationally with zero added latency.

## Interface
- `N_REQ`, default 2: number of requesting sources, 2..8.
- `FLIT_SIZE`, default 32: flit width in bits.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset, asynchronous, active-high.
- `tx_i`  in  N_REQ: per-source flit valid; held high for the whole burst.
- `data_i`  in  N_REQ*FLIT_SIZE: per-source flit; source k occupies bits [k*FLIT_SIZE +: FLIT_SIZE].
- `credit_o`  out  N_REQ: per-source credit; high only for the granted source.
- `tx_o`  out  1: downstream flit valid.
- `credit_i`  in  1: downstream credit.
- `data_o`  out  FLIT_SIZE: downstream flit.
- `grant_o`  out  N_REQ: one-hot current grant; all zero when idle.
- `busy_o`  out  1: high in GRANT state.
- `burst_cnt_o`  out  32: flits transferred in the current or most recent burst.
- `flit_cnt_o`  out  N_REQ*32: per-source cumulative flit count (see Configuration).

## Operation
- A transfer occurs on a rising edge where `tx_o && credit_i`.
- There are two states, IDLE and GRANT. Registers: `state`, `gnt_idx`, `last_idx`, `burst_cnt`.
- **IDLE**
  - Outputs: `tx_o`=0, `credit_o`=0, `data_o`=0, `grant_o`=0, `busy_o`=0.
  - If any `tx_i` bit is high at an edge: select the first requesting index searching `last_idx+1`, `last_idx+2`, … modulo N_REQ.
  - Then load `gnt_idx`, clear `burst_cnt` to 0, and go to GRANT.
- **GRANT** (g = `gnt_idx`)
  - `tx_o` = `tx_i[g]`; `data_o` = `data_i` slice g; `credit_o[g]` = `credit_i`; all other `credit_o` bits = 0.
  - `grant_o` = one-hot(g); `busy_o` = 1.
  - Each transfer increments `burst_cnt` by 1, wrapping modulo 2^32.
  - If `tx_i[g]` is low at an edge: set `last_idx` = g and go to IDLE. `burst_cnt` is retained.
- **Non-granted sources**
  - They see `credit_o`=0 and must hold their data/tx; nothing is dropped.
  - Raising or lowering a non-granted `tx_i` has no effect on the current grant.
- **Boundary conditions**
  - Simultaneous requests: strict rotation from `last_idx+1`, so no source is starved.
  - Granted source drops `tx_i` in the same cycle another source raises it: release happens first; the new source is arbitrated in IDLE on the next edge.
  - Granted source raises `tx_i` again right after release: it competes normally and loses to any other pending requester.
  - `credit_i` low: the burst stalls and the grant is held indefinitely.
- **Reset** (asserted at any time, including mid-burst)
  - Immediately: state=IDLE, `gnt_idx`=0, `last_idx`=N_REQ-1 (so source 0 wins first), `burst_cnt`=0, and all counters 0.
  - All outputs take their IDLE values asynchronously.

## Timing
- Arbitration latency: a request sampled at edge k gives `grant_o` valid after edge k. The first transfer can occur at edge k+1.
- Forwarding: `data_i`/`tx_i` to `data_o`/`tx_o`, and `credit_i` to `credit_o`, are combinational, zero cycles.
- Release: `tx_i[g]` low at edge m gives IDLE after edge m. At least one IDLE bubble cycle separates consecutive bursts.
- `burst_cnt_o` and `flit_cnt_o` update on the edge of the transfer; they are visible the following cycle.

## Configuration
- `INJECT_ARBITER_CNT_EN`
  - Defined: each source has a 32-bit cumulative counter, incremented on every transfer while granted. The counter wraps at 2^32 and is cleared only by reset. Counters are driven on `flit_cnt_o`.
  - Undefined: the counters are not built and `flit_cnt_o` is tied to 0.
- `burst_cnt_o` is present in both builds.

## Test plan
- Single source, `credit_i`=1. Source 0 raises tx with 10 flits 0x1..0xA and drops tx after the last transfer. Required: `grant_o`=01 one cycle later; `data_o` sequence 0x1..0xA, unmodified; `burst_cnt_o`=10; return to IDLE.
- Simultaneous requests after reset: sources 0 and 1 raise tx on the same edge with 3-flit bursts each. Required: source 0 served first, then one IDLE cycle, then source 1. Next contention with both requesting: source 0 wins again (rotation from `last_idx`=1).
- Backpressure: `credit_i` toggles 1,0,0,1 during a 4-flit burst. Required: exactly 4 transfers; `credit_o[1]` stays 0 throughout; `data_o` held while stalled.
- Reset mid-burst: assert `rst_ni` after 5 of 8 flits. Required: `tx_o`, `credit_o`, `grant_o` go to 0 immediately; after deassertion, source 0 is granted first.
- With `INJECT_ARBITER_CNT_EN`: interleave three bursts of 4, 6 and 2 flits from sources 0, 1, 0. Required: `flit_cnt_o` = 6 for source 0 and 6 for source 1. Without the macro: `flit_cnt_o`=0 throughout.
